conv_tap_sequencer: RTL and testbench

Address/control sequencer for the first-layer Q1.7 convolution MAC datapath. Once started, it walks every (filter, output row, output column, kernel row, kernel column, channel) point of a stride-1, zero-padded convolution. Each point is emitted as one valid/ready beat carrying the image address, kernel-memory row, padding flag and accumulator framing markers. It sits between the top-level control (start/done) and a single shared MAC/round/ReLU pipe, and replaces the one-cycle behavioural loop nest with a cycle-accurate schedule.

---
 rtl/conv_tap_sequencer.sv | 129 ++++++++++++
 tb/tb_conv_tap_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tap_sequencer.sv
// Tap sequencer for the shared convolution MAC pipe: walks every (f, i, j, m, n, c)
// point of a stride-1 zero-padded convolution as one valid/ready beat per point.
module conv_tap_sequencer #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int CHANNELS = 3,
  parameter int FILTERS  = 28,
  parameter int K        = 3,
  parameter int PAD      = 1,
  localparam int FW  = (FILTERS > 1) ? $clog2(FILTERS) : 1,
  localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int CLW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int KW  = (K > 1) ? $clog2(K) : 1,
  localparam int AW  = (HEIGHT * WIDTH > 1) ? $clog2(HEIGHT * WIDTH) : 1,
  localparam int KRW = (K * K * CHANNELS > 1) ? $clog2(K * K * CHANNELS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [FW-1:0]  filt,
  output logic [RW-1:0]  out_row,
  output logic [CLW-1:0] out_col,
  output logic [CW-1:0]  chan,
  output logic [AW-1:0]  pix_addr,
  output logic [KRW-1:0] kern_row,
  output logic           pad_zero,
  output logic           acc_first,
  output logic           acc_last
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_n;
  logic [KW-1:0] m_cnt, n_cnt;
  logic clear, step;
  logic c_wrap, n_wrap, m_wrap, j_wrap, i_wrap, f_wrap, last_beat;
  int in_y, in_x;

  assign c_wrap = (chan == CW'(CHANNELS - 1));
  assign n_wrap = (n_cnt == KW'(K - 1));
  assign m_wrap = (m_cnt == KW'(K - 1));
  assign j_wrap = (out_col == CLW'(WIDTH - 1));
  assign i_wrap = (out_row == RW'(HEIGHT - 1));
  assign f_wrap = (filt == FW'(FILTERS - 1));
  assign last_beat = c_wrap && n_wrap && m_wrap && j_wrap && i_wrap && f_wrap;

  // Beat fields are pure functions of the registered counters, so out_ready never reaches them.
  assign in_y = int'(out_row) + int'(m_cnt) - PAD;
  assign in_x = int'(out_col) + int'(n_cnt) - PAD;
  assign pad_zero  = (in_y < 0) || (in_y >= HEIGHT) || (in_x < 0) || (in_x >= WIDTH);
  assign pix_addr  = pad_zero ? '0 : AW'(in_y * WIDTH + in_x);
  assign kern_row  = KRW'(int'(m_cnt) * K * CHANNELS + int'(n_cnt) * CHANNELS + int'(chan));
  assign acc_first = (m_cnt == '0) && (n_cnt == '0) && (chan == '0);
  assign acc_last  = m_wrap && n_wrap && c_wrap;

  assign out_valid = (state == RUN);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    clear   = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = RUN;
          clear   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
          clear   = 1'b1;
        end else if (out_ready) begin
          step = 1'b1;
          if (last_beat) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        if (abort) clear = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Odometer: the final beat wraps every counter back to zero on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      filt    <= '0;
      out_row <= '0;
      out_col <= '0;
      m_cnt   <= '0;
      n_cnt   <= '0;
      chan    <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        filt    <= '0;
        out_row <= '0;
        out_col <= '0;
        m_cnt   <= '0;
        n_cnt   <= '0;
        chan    <= '0;
      end else if (step) begin
        chan <= c_wrap ? '0 : chan + 1'b1;
        if (c_wrap)
          n_cnt <= n_wrap ? '0 : n_cnt + 1'b1;
        if (c_wrap && n_wrap)
          m_cnt <= m_wrap ? '0 : m_cnt + 1'b1;
        if (c_wrap && n_wrap && m_wrap)
          out_col <= j_wrap ? '0 : out_col + 1'b1;
        if (c_wrap && n_wrap && m_wrap && j_wrap)
          out_row <= i_wrap ? '0 : out_row + 1'b1;
        if (c_wrap && n_wrap && m_wrap && j_wrap && i_wrap)
          filt <= f_wrap ? '0 : filt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Bench for conv_tap_sequencer: a beat-index model decoded by mixed-radix arithmetic,
// checked every cycle, plus directed passes (backpressure, abort, reset, degenerate config).
module tb_conv_tap_sequencer;

  localparam int W = 4, H = 4, C = 3, F = 2, KK = 3, P = 1;
  localparam int TOTAL = F * H * W * KK * KK * C;

  typedef struct {
    int filt, row, col, chan, pix, kern, pad, first, last;
  } beat_t;

  logic clk, rst, start, abort, out_ready;
  logic busy, done, out_valid, pad_zero, acc_first, acc_last;
  logic [0:0] filt;
  logic [1:0] out_row, out_col, chan;
  logic [3:0] pix_addr;
  logic [4:0] kern_row;

  logic dg_start, dg_ready, dg_busy, dg_done, dg_valid, dg_pad, dg_first, dg_last;
  logic [0:0] dg_filt, dg_row, dg_col, dg_pix;
  logic [1:0] dg_chan, dg_kern;

  int tests = 0, fails = 0;
  int m_idx = 0, exp_run = 0, exp_done = 0;
  int obs_beats = 0, done_count = 0;
  bit log_en = 0;
  int log_pix[TOTAL], log_kern[TOTAL], log_pad[TOTAL];
  int log_first[TOTAL], log_last[TOTAL], log_col[TOTAL];

  conv_tap_sequencer #(.WIDTH(W), .HEIGHT(H), .CHANNELS(C), .FILTERS(F), .K(KK), .PAD(P)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .filt(filt), .out_row(out_row),
    .out_col(out_col), .chan(chan), .pix_addr(pix_addr), .kern_row(kern_row),
    .pad_zero(pad_zero), .acc_first(acc_first), .acc_last(acc_last)
  );

  conv_tap_sequencer #(.WIDTH(1), .HEIGHT(1), .CHANNELS(3), .FILTERS(2), .K(1), .PAD(0)) dg (
    .clk(clk), .rst(rst), .start(dg_start), .abort(1'b0), .busy(dg_busy), .done(dg_done),
    .out_valid(dg_valid), .out_ready(dg_ready), .filt(dg_filt), .out_row(dg_row),
    .out_col(dg_col), .chan(dg_chan), .pix_addr(dg_pix), .kern_row(dg_kern),
    .pad_zero(dg_pad), .acc_first(dg_first), .acc_last(dg_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Decode a beat index into its loop coordinates, innermost (c) first.
  function automatic beat_t model_beat(input int idx, input int w, input int h, input int c,
                                       input int k, input int p);
    beat_t b;
    int rem, m, n, y, x;
    rem = idx;
    b.chan = rem % c; rem = rem / c;
    n      = rem % k; rem = rem / k;
    m      = rem % k; rem = rem / k;
    b.col  = rem % w; rem = rem / w;
    b.row  = rem % h; rem = rem / h;
    b.filt = rem;
    y = b.row + m - p;
    x = b.col + n - p;
    b.pad   = (y < 0 || y >= h || x < 0 || x >= w) ? 1 : 0;
    b.pix   = b.pad ? 0 : y * w + x;
    b.kern  = (m * k + n) * c + b.chan;
    b.first = (m == 0 && n == 0 && b.chan == 0) ? 1 : 0;
    b.last  = (m == k - 1 && n == k - 1 && b.chan == c - 1) ? 1 : 0;
    return b;
  endfunction

  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      m_idx = 0; exp_run = 0; exp_done = 0;
    end else begin
      checkOutput("out_valid", int'(out_valid), exp_run);
      checkOutput("done", int'(done), exp_done);
      checkOutput("busy", int'(busy), (exp_run != 0 || exp_done != 0) ? 1 : 0);
      if (exp_run != 0) begin
        b = model_beat(m_idx, W, H, C, KK, P);
        checkOutput("filt", int'(filt), b.filt);
        checkOutput("out_row", int'(out_row), b.row);
        checkOutput("out_col", int'(out_col), b.col);
        checkOutput("chan", int'(chan), b.chan);
        checkOutput("pix_addr", int'(pix_addr), b.pix);
        checkOutput("kern_row", int'(kern_row), b.kern);
        checkOutput("pad_zero", int'(pad_zero), b.pad);
        checkOutput("acc_first", int'(acc_first), b.first);
        checkOutput("acc_last", int'(acc_last), b.last);
      end
      if (out_valid && out_ready && !abort) begin
        if (log_en && obs_beats >= 0) begin
          if (m_idx < TOTAL) begin
            log_pix[m_idx] = int'(pix_addr);   log_kern[m_idx] = int'(kern_row);
            log_pad[m_idx] = int'(pad_zero);   log_first[m_idx] = int'(acc_first);
            log_last[m_idx] = int'(acc_last);  log_col[m_idx] = int'(out_col);
          end
        end
        obs_beats++;
      end
      if (done) done_count++;
      if (exp_done != 0) exp_done = 0;
      else if (exp_run != 0) begin
        if (abort) begin
          exp_run = 0; m_idx = 0;
        end else if (out_ready) begin
          if (m_idx == TOTAL - 1) begin
            exp_run = 0; exp_done = 1; m_idx = 0;
          end else m_idx++;
        end
      end else if (start && !abort) begin
        exp_run = 1; m_idx = 0;
      end
    end
  end

  task automatic applyStimulus(input bit s, input bit a, input bit r);
    start = s; abort = a; out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic runUntilDone(input bit random_ready, input int budget, input int d0);
    bit seen = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done_count != d0) begin
        seen = 1;
        break;
      end
      applyStimulus(1'b0, 1'b0, random_ready ? ($urandom_range(0, 9) < 3) : 1'b1);
    end
    if (!seen) checkOutput("done_timeout", 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  task automatic runDegenerate();
    int nb = 0, nd = 0;
    dg_ready = 1'b1;
    dg_start = 1'b1;
    @(posedge clk); #2;
    dg_start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (dg_valid) begin
        checkOutput("dg_pad_zero", int'(dg_pad), 0);
        checkOutput("dg_pix_addr", int'(dg_pix), 0);
        checkOutput("dg_filt", int'(dg_filt), nb / 3);
        checkOutput("dg_chan", int'(dg_chan), nb % 3);
        nb++;
      end
      if (dg_done) nd++;
    end
    checkOutput("dg_beats", nb, F * 3);
    checkOutput("dg_done_pulses", nd, 1);
  endtask

  initial begin
    beat_t mb;
    int b0, d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    dg_start = 1'b0; dg_ready = 1'b0;

    // Pin the model itself against hand-derived beats.
    mb = model_beat(0, W, H, C, KK, P);
    checkOutput("model_b0_pad", mb.pad, 1);
    mb = model_beat(12, W, H, C, KK, P);
    checkOutput("model_b12_kern", mb.kern, 12);
    checkOutput("model_b12_pad", mb.pad, 0);
    mb = model_beat(160, W, H, C, KK, P);
    checkOutput("model_b160_pix", mb.pix, 10);
    checkOutput("model_b160_kern", mb.kern, 25);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_pad_zero", int'(pad_zero), 1);
    checkOutput("rst_acc_first", int'(acc_first), 1);
    checkOutput("rst_acc_last", int'(acc_last), 0);
    checkOutput("rst_pix_addr", int'(pix_addr), 0);
    checkOutput("rst_kern_row", int'(kern_row), 0);

    b0 = obs_beats;
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_beats", obs_beats - b0, 0);

    // Full pass with a stray start mid-pass.
    log_en = 1; b0 = obs_beats; d0 = done_count;
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (50) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runUntilDone(1'b0, 2000, d0);
    log_en = 0;
    checkOutput("pass1_beats", obs_beats - b0, TOTAL);
    checkOutput("pass1_done_pulses", done_count - d0, 1);
    checkOutput("log_b0_pad", log_pad[0], 1);
    checkOutput("log_b0_first", log_first[0], 1);
    checkOutput("log_b12_pix", log_pix[12], 0);
    checkOutput("log_b12_kern", log_kern[12], 12);
    checkOutput("log_b12_pad", log_pad[12], 0);
    checkOutput("log_b26_last", log_last[26], 1);
    checkOutput("log_b27_col", log_col[27], 1);
    checkOutput("log_b27_first", log_first[27], 1);
    checkOutput("log_b160_pix", log_pix[160], 10);
    checkOutput("log_b160_kern", log_kern[160], 25);

    b0 = obs_beats; d0 = done_count;
    applyStimulus(1'b1, 1'b0, 1'b0);
    runUntilDone(1'b1, 20000, d0);
    checkOutput("bp_beats", obs_beats - b0, TOTAL);
    checkOutput("bp_done_pulses", done_count - d0, 1);

    b0 = obs_beats; d0 = done_count;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (exp_run != 0 && m_idx == 100) break;
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort_out_valid", int'(out_valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_beats", obs_beats - b0, 100);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_no_done", done_count - d0, 0);

    b0 = obs_beats; d0 = done_count;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("restart_acc_first", int'(acc_first), 1);
    checkOutput("restart_out_col", int'(out_col), 0);
    runUntilDone(1'b0, 2000, d0);
    checkOutput("restart_beats", obs_beats - b0, TOTAL);

    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (30) applyStimulus(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    b0 = obs_beats;
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("midrst_no_resume", obs_beats - b0, 0);

    runDegenerate();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
